// File: rtl/roce_egress_framer.sv
// RoCE egress framer: pops one descriptor per frame, streams the matching data
// words onto AXI-Stream with start/last/keep/user, and drains illegal-length frames.
`timescale 1ns/1ps

module roce_egress_framer #(
    parameter int DATA_WIDTH      = 256,
    parameter int KEEP_WIDTH      = 32,
    parameter int DESC_WIDTH      = 192,
    parameter int MAX_FRAME_BYTES = 9600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_desc_empty,
    output logic                  o_desc_rd_en,
    input  logic [DESC_WIDTH-1:0] iv_desc_data,
    input  logic                  i_roce_egress_empty,
    output logic                  o_roce_egress_rd_en,
    input  logic [DATA_WIDTH-1:0] iv_roce_egress_data,
    output logic                  o_eth_tx_valid,
    output logic                  o_eth_tx_last,
    output logic [DATA_WIDTH-1:0] ov_eth_tx_data,
    output logic [KEEP_WIDTH-1:0] ov_eth_tx_keep,
    input  logic                  i_eth_tx_ready,
    output logic                  o_eth_tx_start,
    output logic [15:0]           ov_eth_tx_user,
    output logic [31:0]           ov_tx_frame_cnt,
    output logic [31:0]           ov_tx_drop_cnt,
    output logic                  o_idle
);

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [10:0]           beats_q, beats_d;
    logic [4:0]            tail_q, tail_d;
    logic [10:0]           cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [15:0]           user_q, user_d;
    logic [31:0]           frame_q, frame_d;
    logic [31:0]           drop_q, drop_d;
    logic                  desc_rd;
    logic                  data_rd;

    logic [15:0] desc_len;
    logic [16:0] desc_sum;
    logic [10:0] desc_beats;
    logic        desc_bad;
    logic        beat_is_last;
    logic        unused_bits;

    assign desc_len     = iv_desc_data[15:0];
    assign desc_sum     = {1'b0, desc_len} + 17'd31;
    assign desc_beats   = desc_sum[15:5];
    assign desc_bad     = (desc_len == 16'd0) || (desc_len > 16'(MAX_FRAME_BYTES));
    assign beat_is_last = (cnt_q == beats_q - 11'd1);
    assign unused_bits  = ^{iv_desc_data[DESC_WIDTH-1:16], desc_sum[16], desc_sum[4:0]};

    // Byte enables for the final beat; a zero tail means the beat is full.
    function automatic logic [KEEP_WIDTH-1:0] tail_keep(input logic [4:0] t);
        logic [KEEP_WIDTH-1:0] k;
        k = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (i < int'(t)) k[i] = 1'b1;
        end
        if (t == 5'd0) k = '1;
        return k;
    endfunction

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beats_d = beats_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        start_d = start_q;
        data_d  = data_q;
        keep_d  = keep_q;
        user_d  = user_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        desc_rd = 1'b0;
        data_rd = 1'b0;

        if (valid_q && i_eth_tx_ready) begin
            valid_d = 1'b0;
            if (last_q) frame_d = frame_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (!i_desc_empty) begin
                    desc_rd = 1'b1;
                    len_d   = desc_len;
                    beats_d = desc_beats;
                    tail_d  = desc_len[4:0];
                    cnt_d   = 11'd0;
                    state_d = desc_bad ? DROP : STREAM;
                end
            end
            STREAM: begin
                if (!i_roce_egress_empty && (!valid_q || i_eth_tx_ready)) begin
                    data_rd = 1'b1;
                    valid_d = 1'b1;
                    data_d  = iv_roce_egress_data;
                    start_d = (cnt_q == 11'd0);
                    last_d  = beat_is_last;
                    keep_d  = beat_is_last ? tail_keep(tail_q) : '1;
                    user_d  = len_q;
                    cnt_d   = cnt_q + 11'd1;
                    if (beat_is_last) state_d = IDLE;
                end
            end
            DROP: begin
                // Zero-beat descriptors retire without touching the data FIFO.
                if (beats_q == 11'd0) begin
                    drop_d  = drop_q + 32'd1;
                    state_d = IDLE;
                end else if (!i_roce_egress_empty) begin
                    data_rd = 1'b1;
                    cnt_d   = cnt_q + 11'd1;
                    if (beat_is_last) begin
                        drop_d  = drop_q + 32'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            beats_q <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            start_q <= start_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            user_q  <= user_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    // Descriptor pop is gated by reset so the FIFO is never popped while held in reset.
    assign o_desc_rd_en        = desc_rd && rst;
    assign o_roce_egress_rd_en = data_rd;
    assign o_eth_tx_valid      = valid_q;
    assign o_eth_tx_last       = last_q;
    assign o_eth_tx_start      = start_q;
    assign ov_eth_tx_data      = data_q;
    assign ov_eth_tx_keep      = keep_q;
    assign ov_eth_tx_user      = user_q;
    assign ov_tx_frame_cnt     = frame_q;
    assign ov_tx_drop_cnt      = drop_q;
    assign o_idle              = (state_q == IDLE) && !valid_q;

endmodule

// File: tb/tb_roce_egress_framer.sv
// Bench for roce_egress_framer: queue-modelled FWFT FIFOs and an expected-beat scoreboard.
`timescale 1ns/1ps

module tb_roce_egress_framer;

    localparam int DW  = 256;
    localparam int KW  = 32;
    localparam int DSW = 192;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           i_desc_empty = 1'b1;
    logic           o_desc_rd_en;
    logic [DSW-1:0] iv_desc_data = '0;
    logic           i_roce_egress_empty = 1'b1;
    logic           o_roce_egress_rd_en;
    logic [DW-1:0]  iv_roce_egress_data = '0;
    logic           o_eth_tx_valid;
    logic           o_eth_tx_last;
    logic [DW-1:0]  ov_eth_tx_data;
    logic [KW-1:0]  ov_eth_tx_keep;
    logic           i_eth_tx_ready = 1'b0;
    logic           o_eth_tx_start;
    logic [15:0]    ov_eth_tx_user;
    logic [31:0]    ov_tx_frame_cnt;
    logic [31:0]    ov_tx_drop_cnt;
    logic           o_idle;

    roce_egress_framer dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_desc_empty        (i_desc_empty),
        .o_desc_rd_en        (o_desc_rd_en),
        .iv_desc_data        (iv_desc_data),
        .i_roce_egress_empty (i_roce_egress_empty),
        .o_roce_egress_rd_en (o_roce_egress_rd_en),
        .iv_roce_egress_data (iv_roce_egress_data),
        .o_eth_tx_valid      (o_eth_tx_valid),
        .o_eth_tx_last       (o_eth_tx_last),
        .ov_eth_tx_data      (ov_eth_tx_data),
        .ov_eth_tx_keep      (ov_eth_tx_keep),
        .i_eth_tx_ready      (i_eth_tx_ready),
        .o_eth_tx_start      (o_eth_tx_start),
        .ov_eth_tx_user      (ov_eth_tx_user),
        .ov_tx_frame_cnt     (ov_tx_frame_cnt),
        .ov_tx_drop_cnt      (ov_tx_drop_cnt),
        .o_idle              (o_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          start;
        logic [15:0]   user;
    } beat_t;

    logic [DSW-1:0] dq[$];
    logic [DW-1:0]  wq[$];
    logic [DW-1:0]  pend_q[$];
    beat_t          exp_q[$];

    int   checks = 0;
    int   errors = 0;
    bit   dpop_s = 1'b0;
    bit   wpop_s = 1'b0;
    bit   vld_s  = 1'b0;
    bit   hold_s = 1'b0;
    beat_t held;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic refresh();
        i_desc_empty        = (dq.size() == 0);
        iv_desc_data        = (dq.size() != 0) ? dq[0] : '0;
        i_roce_egress_empty = (wq.size() == 0);
        iv_roce_egress_data = (wq.size() != 0) ? wq[0] : '0;
    endtask

    // Queue a descriptor plus nwords data words; only the first nnow become visible now.
    task automatic push_frame(input int len, input int nwords, input int nnow, input bit legal);
        logic [DW-1:0]  w;
        logic [DSW-1:0] d;
        beat_t          e;
        w = rand_word();
        d = w[DSW-1:0];
        d[15:0] = len[15:0];
        dq.push_back(d);
        for (int i = 0; i < nwords; i++) begin
            w = rand_word();
            if (i < nnow) wq.push_back(w);
            else          pend_q.push_back(w);
            if (legal) begin
                e.data  = w;
                e.start = (i == 0);
                e.last  = (i == nwords - 1);
                e.user  = len[15:0];
                e.keep  = '1;
                if (e.last && (len % 32) != 0) begin
                    e.keep = '0;
                    for (int b = 0; b < len % 32; b++) e.keep[b] = 1'b1;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic release_pending();
        while (pend_q.size() != 0) wq.push_back(pend_q.pop_front());
    endtask

    // One clock: retire the pops seen last cycle, drive inputs, sample just before the edge.
    task automatic step(input bit rdy);
        logic [DSW-1:0] td;
        logic [DW-1:0]  tw;
        beat_t          e;
        @(negedge clk);
        if (dpop_s && dq.size() != 0) td = dq.pop_front();
        if (wpop_s && wq.size() != 0) tw = wq.pop_front();
        refresh();
        i_eth_tx_ready = rdy;
        #4;
        dpop_s = o_desc_rd_en;
        wpop_s = o_roce_egress_rd_en;
        vld_s  = o_eth_tx_valid;
        check("desc_pop_while_empty", {31'd0, o_desc_rd_en & i_desc_empty}, '0);
        check("data_pop_while_empty", {31'd0, o_roce_egress_rd_en & i_roce_egress_empty}, '0);
        if (hold_s) begin
            check("hold_valid", {31'd0, o_eth_tx_valid}, 1);
            check("hold_data", ov_eth_tx_data, held.data);
            check("hold_keep", ov_eth_tx_keep, held.keep);
            check("hold_flags", {o_eth_tx_last, o_eth_tx_start, ov_eth_tx_user},
                  {held.last, held.start, held.user});
        end
        if (o_eth_tx_valid && i_eth_tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {31'd0, o_eth_tx_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", ov_eth_tx_data, e.data);
                check("beat_keep", ov_eth_tx_keep, e.keep);
                check("beat_start", {31'd0, o_eth_tx_start}, {31'd0, e.start});
                check("beat_last", {31'd0, o_eth_tx_last}, {31'd0, e.last});
                check("beat_user", ov_eth_tx_user, e.user);
            end
        end
        hold_s     = o_eth_tx_valid && !i_eth_tx_ready;
        held.data  = ov_eth_tx_data;
        held.keep  = ov_eth_tx_keep;
        held.last  = o_eth_tx_last;
        held.start = o_eth_tx_start;
        held.user  = ov_eth_tx_user;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {o_desc_rd_en, o_roce_egress_rd_en, o_eth_tx_valid, o_eth_tx_last,
              o_eth_tx_start, ov_eth_tx_keep, ov_eth_tx_user}, '0);
        check({tag, "_data"}, ov_eth_tx_data, '0);
        check({tag, "_cnts"}, {ov_tx_frame_cnt, ov_tx_drop_cnt}, '0);
    endtask

    logic [7:0] vpat;
    int         vcount;
    bit         rpat[7];

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        check("reset_idle", {31'd0, o_idle}, 1);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1);

        // Single frame, len=100, first valid two cycles after the descriptor appears
        push_frame(100, 4, 4, 1'b1);
        step(1'b1); check("t1_valid_c0", {31'd0, vld_s}, 0);
        step(1'b1); check("t1_valid_c1", {31'd0, vld_s}, 0);
        step(1'b1); check("t1_valid_c2", {31'd0, vld_s}, 1);
        for (int i = 0; i < 6; i++) step(1'b1);
        check("t1_frame_cnt", ov_tx_frame_cnt, 1);
        check("t1_sb_empty", exp_q.size(), 0);

        // Exact multiple with backpressure
        push_frame(64, 2, 2, 1'b1);
        rpat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) step(rpat[i]);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t2_frame_cnt", ov_tx_frame_cnt, 2);
        check("t2_sb_empty", exp_q.size(), 0);

        // Back-to-back frames: valid expected in cycles 2, 4, 5
        push_frame(32, 1, 1, 1'b1);
        push_frame(33, 2, 2, 1'b1);
        vpat = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            vpat[i] = vld_s;
        end
        check("t3_valid_pattern", vpat, 8'h34);
        step(1'b1);
        check("t3_frame_cnt", ov_tx_frame_cnt, 4);

        // Illegal lengths are drained; only the 40-byte frame appears
        push_frame(9601, 301, 301, 1'b0);
        push_frame(0, 0, 0, 1'b0);
        push_frame(40, 2, 2, 1'b1);
        for (int i = 0; i < 330; i++) step(1'b1);
        check("t4_drop_cnt", ov_tx_drop_cnt, 2);
        check("t4_words_drained", wq.size(), 0);
        check("t4_desc_drained", dq.size(), 0);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_frame_cnt", ov_tx_frame_cnt, 5);

        // Data underrun after the first word
        push_frame(96, 3, 1, 1'b1);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            if (vld_s) vcount++;
        end
        check("t5_valid_during_underrun", vcount, 1);
        release_pending();
        for (int i = 0; i < 6; i++) step(1'b1);
        check("t5_frame_cnt", ov_tx_frame_cnt, 6);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset asserted while beat 2 of a 4-beat frame is on the bus
        push_frame(128, 4, 4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("t6_beat2_valid", {31'd0, vld_s}, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        dq.delete(); wq.delete(); pend_q.delete(); exp_q.delete();
        dpop_s = 1'b0; wpop_s = 1'b0; hold_s = 1'b0;
        refresh();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1);
        check("t6_idle_after", {31'd0, o_idle}, 1);
        check("t6_cnts_after", {ov_tx_frame_cnt, ov_tx_drop_cnt}, '0);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            if (vld_s) vcount++;
        end
        check("t6_no_valid_after", vcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/roce_egress_framer.md
# roce_egress_framer

Egress stage between the RoCE egress data FIFO / RoCE descriptor FIFO pair and the Ethernet MAC transmit port. It pops one descriptor per frame, streams the matching number of 256-bit data words out on an AXI-Stream interface with correct `tlast`/`tkeep`, and drains frames whose descriptor length is illegal. Both input FIFOs are first-word-fall-through, read with `rd_en`. The block is the downstream consumer of the RoCE egress and descriptor FIFOs inside the miscellaneous layer.

## Interface
- `DATA_WIDTH`, 256, data word width in bits.
- `KEEP_WIDTH`, 32, byte-enable width; must equal `DATA_WIDTH/8`.
- `DESC_WIDTH`, 192, descriptor width; bits [15:0] hold the frame length in bytes, and the other bits are ignored.
- `MAX_FRAME_BYTES`, 9600, largest legal frame length.
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `i_desc_empty`  in  1  descriptor FIFO empty.
- `o_desc_rd_en`  out  1  descriptor FIFO pop.
- `iv_desc_data`  in  DESC_WIDTH  descriptor FIFO head word.
- `i_roce_egress_empty`  in  1  data FIFO empty.
- `o_roce_egress_rd_en`  out  1  data FIFO pop.
- `iv_roce_egress_data`  in  DATA_WIDTH  data FIFO head word.
- `o_eth_tx_valid`  out  1  AXIS valid.
- `o_eth_tx_last`  out  1  last beat of the frame.
- `ov_eth_tx_data`  out  DATA_WIDTH  beat data; byte 0 sits at [7:0].
- `ov_eth_tx_keep`  out  KEEP_WIDTH  byte enables; `keep[i]` covers byte i.
- `i_eth_tx_ready`  in  1  AXIS ready.
- `o_eth_tx_start`  out  1  first beat of the frame.
- `ov_eth_tx_user`  out  16  frame length in bytes, held constant on every beat of the frame.
- `ov_tx_frame_cnt`  out  32  count of frames fully transmitted.
- `ov_tx_drop_cnt`  out  32  count of frames discarded.
- `o_idle`  out  1  high when the block is in IDLE and the output register is empty.

## Operation
- States: IDLE, STREAM, DROP.
- **IDLE**
  - When `!i_desc_empty`, assert `o_desc_rd_en` for exactly 1 cycle.
  - In the same cycle, latch `len = iv_desc_data[15:0]`.
  - Compute `beats = (len+31)>>5` using 11-bit arithmetic.
  - Compute `tail = len[4:0]`; `tail` 0 means a full 32-byte last beat.
  - Next state: DROP if `len==0` or `len>MAX_FRAME_BYTES`, else STREAM.
  - A `len` of 0 in DROP pops no data words.
- **STREAM**
  - Pop condition: `!i_roce_egress_empty && (!o_eth_tx_valid || i_eth_tx_ready)`.
  - On a pop, load the output register with:
    - `valid=1` and data = head word;
    - `start = (beat_cnt==0)`;
    - `last = (beat_cnt==beats-1)`;
    - `keep` = all ones, or on the last beat `(1<<tail)-1` (all ones when `tail==0`);
    - `user = len`.
  - `beat_cnt` increments on each pop.
  - On the pop of the last beat, return to IDLE.
- **Output register**
  - When `o_eth_tx_valid && i_eth_tx_ready` and no new pop occurs, clear valid.
  - `ov_tx_frame_cnt` increments on the handshake of a beat with `last=1`.
- **DROP**
  - Pop one data word per cycle whenever `!i_roce_egress_empty`, independent of `i_eth_tx_ready`.
  - Nothing is presented on AXIS.
  - After `beats` pops (or immediately when `len==0`):
    - increment `ov_tx_drop_cnt`;
    - go to IDLE.
- **Counters** are 32-bit and wrap modulo 2^32.
- **Empty data FIFO mid-frame:** stall with no pop. Valid deasserts only after the current beat is accepted.

## Timing
- Reset values: every output 0, both counters 0, state IDLE, `o_idle=1`.
- Reset asserted mid-frame: the partial frame is abandoned with no `last`. Upstream FIFOs are reset by the same reset.
- Latency: descriptor at the FIFO head in cycle 0 (IDLE) → first data pop in cycle 1 → `o_eth_tx_valid` high in cycle 2. This assumes the data FIFO is non-empty and the output register is free.
- Throughput: 1 beat per cycle within a frame while ready is held high.
- Frame gap: exactly 1 idle cycle between frames, for the descriptor pop.
- AXIS rules:
  - data, keep, last, start and user are stable while `valid && !ready`;
  - valid never drops without a handshake.
- `o_desc_rd_en` and `o_roce_egress_rd_en` are never asserted while the corresponding empty is high.
- `o_desc_rd_en` is never asserted in STREAM or DROP.
- Simultaneous handshake and pop in the same cycle: the register reloads and valid stays high.

## Test plan
- **Single frame.** Descriptor `len=100`, 4 data words, ready held at 1 → 4 beats on AXIS:
  - `start` on beat 0 and `last` on beat 3;
  - keep = `0xFFFFFFFF` ×3, then `0x0000000F`;
  - `user=100` on all beats;
  - `ov_tx_frame_cnt=1`;
  - first valid 2 cycles after the descriptor appears.
- **Exact multiple and backpressure.** `len=64`, ready toggling 1,0,0,1 → 2 beats, last keep `0xFFFFFFFF`, data/keep/last held stable during the ready=0 cycles, no FIFO pops while stalled.
- **Back-to-back frames.** `len=32` then `len=33`, both fully pre-loaded → beats appear in cycles 2, 4, 5:
  - beat 3 has keep `0x00000001`;
  - frame count reaches 2.
- **Illegal lengths.** `len=9601` with 301 words, then `len=0` with no words, then `len=40` with 2 words:
  - 301 words are drained;
  - `ov_tx_drop_cnt=2`;
  - only the 40-byte frame appears on AXIS.
- **Data underrun.** `len=96` with the data FIFO empty for 5 cycles after the first word → beat 0 is sent, no spurious valid during the underrun, and the frame completes once words arrive.
- **Reset mid-frame.** Assert `rst=0` during beat 2 of a 4-beat frame:
  - all outputs go to 0 immediately (asynchronously);
  - after release, `o_idle=1` and the counters read 0.
